fir_tdm_sequencer: RTL and testbench
====================================

Name: fir_tdm_sequencer

Overview:
- Shares one multichannel (time-interleaved) FIR instance between NCH sample streams, e.g. the I and Q mixer outputs of the demodulator.
- Collects one sample per channel into a frame and issues the frame to the FIR Avalon-ST sink in strict channel order 0..NCH-1, honouring sink ready.
- Demultiplexes the interleaved FIR source stream back into per-channel registered outputs.
- Sits between the ADC/mixer stage and the per-channel demodulation back-end, in the clk domain.

Parameters:
- NCH, 2, number of interleaved channels (2..8); must equal the FIR's configured channel count.
- DW, 12, input sample width, signed two's complement.
- OW, 12, FIR output width, signed.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  NCH  per-channel one-cycle sample strobe.
- in_data  in  NCH*DW  packed samples; channel k at bits [k*DW +: DW].
- flush  in  1  synchronous pulse; abandons the partial frame and output alignment.
- clr_overflow  in  1  synchronous pulse; clears the overflow flags.
- fir_sink_data  out  DW  sample presented to the FIR.
- fir_sink_valid  out  1  sink valid.
- fir_sink_ready  in  1  FIR sink ready.
- fir_source_data  in  OW  FIR output sample.
- fir_source_valid  in  1  FIR output valid.
- fir_source_ready  out  1  constant 1 (the block never back-pressures).
- out_data  out  NCH*OW  per-channel latest filtered sample, packed.
- out_valid  out  NCH  one-cycle pulse when the corresponding out_data slice updates.
- frame_valid  out  1  one-cycle pulse coincident with out_valid[NCH-1].
- overflow  out  NCH  sticky per-channel overrun flag.
- busy  out  1  high in the ISSUE state.

Behaviour:
- Reset clears all registers:
  - pending, hold and issued registers = 0.
  - FSM = COLLECT; issue index = 0; output channel counter = 0.
  - fir_sink_valid = 0; fir_sink_data = 0.
  - out_data = 0; out_valid = 0; frame_valid = 0; overflow = 0; busy = 0.
- Reset asserted mid-frame discards everything; no partial output is produced.
- Input latch, per channel k:
  - If in_valid[k] and pending[k]=0: hold[k] <= in_data slice; pending[k] <= 1.
  - If in_valid[k] and pending[k]=1 and not being issued this cycle: the sample is dropped, hold[k] is unchanged, overflow[k] <= 1.
  - If in_valid[k] arrives in the same cycle channel k's sample is accepted by the FIR: the new sample is latched (pending[k] stays 1, hold[k] takes the new data) and belongs to the next frame. No overflow is flagged.
- FSM:
  - COLLECT: when all pending bits are 1, go to ISSUE. Next cycle: fir_sink_valid=1, fir_sink_data=hold[0], index=0.
  - ISSUE: a transfer occurs when fir_sink_valid and fir_sink_ready are both 1.
    - On transfer, pending[index] <= 0 unless rule (c) applies, and index advances.
    - fir_sink_data is updated to hold[index+1] in the same registered step.
    - Transfer of channel NCH-1: fir_sink_valid <= 0, index <= 0, go to COLLECT.
    - While fir_sink_ready=0, fir_sink_valid and fir_sink_data hold steady (Avalon-ST rule).
  - Minimum frame cost: NCH transfer cycles plus 1 COLLECT cycle.
- Output demux:
  - On fir_source_valid, the out_data slice at the output channel counter is loaded with fir_source_data.
  - out_valid[counter] pulses on the following cycle (1-cycle latency, registered).
  - The counter increments and wraps from NCH-1 to 0.
  - frame_valid pulses with out_valid[NCH-1].
  - Unselected out_data slices hold their values.
- flush:
  - Clears pending, index and output counter; FSM = COLLECT; fir_sink_valid = 0.
  - overflow and out_data are retained.
  - flush has priority over a same-cycle in_valid; that sample is dropped without raising overflow.
  - After flush, the FIR must also be reset by the owner to restore channel alignment.
- clr_overflow clears all overflow bits. A same-cycle new overrun wins and its bit stays set.
- Arithmetic is pass-through only; no width conversion; samples are signed.

Test Plan:
- NCH=2, ready=1. Strobe in_valid=2'b11 with data ch0=12'h123, ch1=12'hE00 -> transfers 12'h123 then 12'hE00 on consecutive cycles; busy high for 2 cycles; fir_sink_valid low afterwards.
- Back-pressure: fir_sink_ready low for 3 cycles while ch0 is presented -> fir_sink_data stays 12'h123 and fir_sink_valid stays 1 throughout; ch1 is transferred 1 cycle after ready rises.
- Overrun: strobe ch0 twice (12'h010 then 12'h020) before ch1 arrives -> frame issues 12'h010; overflow=2'b01; clr_overflow returns it to 0.
- Same-cycle re-latch: in_valid[0] with 12'h055 on the cycle ch0 is accepted -> no overflow; 12'h055 becomes ch0 of the next frame.
- Source demux: drive fir_source_valid with 12'h7FF then 12'h800 -> out_valid[0] then out_valid[1], each 1 cycle after its input; frame_valid coincident with out_valid[1]; out_data = {12'h800, 12'h7FF}.
- Assert rst_n low mid-ISSUE, or pulse flush after ch0 only -> fir_sink_valid=0 next cycle (asynchronously for reset); the next frame starts at ch0; output counter restarts at 0.

Source files
------------

// File: rtl/fir_tdm_sequencer.sv
// fir_tdm_sequencer
// Shares one time-interleaved FIR between NCH sample streams. One sample per
// channel is collected into a frame. The frame is then issued to the FIR
// Avalon-ST sink in channel order 0..NCH-1. The interleaved FIR source
// stream is demultiplexed back into per-channel registered outputs.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid[NCH]     per-channel one-cycle sample strobe
//   in_data           packed samples, channel k at [k*DW +: DW]
//   flush             abandon the partial frame and the output alignment
//   clr_overflow      clear the sticky overflow flags
//   fir_sink_*        Avalon-ST source towards the FIR sink (data/valid/ready)
//   fir_source_*      Avalon-ST sink from the FIR source (ready tied high)
//   out_data          per-channel latest filtered sample, packed like in_data
//   out_valid[NCH]    one-cycle pulse when the matching out_data slice updates
//   frame_valid       pulse coincident with out_valid[NCH-1]
//   overflow[NCH]     sticky per-channel overrun flag
//   busy              high while the frame is being issued (FSM in ISSUE)
//
// Handshake: a sink transfer happens on a cycle where fir_sink_valid and
// fir_sink_ready are both 1. Once valid is raised, valid and data stay
// unchanged until that transfer happens.
module fir_tdm_sequencer #(
    parameter int NCH = 2,
    parameter int DW  = 12,
    parameter int OW  = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    in_valid,
    input  logic [NCH*DW-1:0] in_data,
    input  logic              flush,
    input  logic              clr_overflow,
    output logic [DW-1:0]     fir_sink_data,
    output logic              fir_sink_valid,
    input  logic              fir_sink_ready,
    input  logic [OW-1:0]     fir_source_data,
    input  logic              fir_source_valid,
    output logic              fir_source_ready,
    output logic [NCH*OW-1:0] out_data,
    output logic [NCH-1:0]    out_valid,
    output logic              frame_valid,
    output logic [NCH-1:0]    overflow,
    output logic              busy
);
    localparam int IW = $clog2(NCH);
    localparam logic [IW-1:0] LAST = IW'(NCH - 1);

    typedef enum logic {S_COLLECT, S_ISSUE} state_t;

    state_t                 state_q, state_d;
    logic [NCH-1:0]         pending_q, pending_d;
    logic [NCH-1:0][DW-1:0] hold_q, hold_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic                   sink_valid_q, sink_valid_d;
    logic [DW-1:0]          sink_data_q, sink_data_d;
    logic [IW-1:0]          ocnt_q, ocnt_d;
    logic [NCH-1:0][OW-1:0] out_data_q, out_data_d;
    logic [NCH-1:0]         out_valid_q, out_valid_d;
    logic                   frame_valid_q, frame_valid_d;
    logic [NCH-1:0]         overflow_q, overflow_d;

    logic                   xfer;
    logic [NCH-1:0]         accept;
    logic [NCH-1:0]         overrun;
    logic [IW-1:0]          idx_next;

    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        hold_d        = hold_q;
        idx_d         = idx_q;
        sink_valid_d  = sink_valid_q;
        sink_data_d   = sink_data_q;
        ocnt_d        = ocnt_q;
        out_data_d    = out_data_q;
        out_valid_d   = '0;
        frame_valid_d = 1'b0;
        overrun       = '0;
        accept        = '0;
        idx_next      = idx_q + IW'(1);

        xfer = (state_q == S_ISSUE) && sink_valid_q && fir_sink_ready;
        if (xfer) begin
            accept[idx_q] = 1'b1;
        end

        // Input latch. A strobe on the cycle a channel is being accepted
        // refills its slot for the next frame instead of counting as overrun.
        for (int k = 0; k < NCH; k++) begin
            if (flush) begin
                pending_d[k] = 1'b0;
            end else if (in_valid[k]) begin
                if (!pending_q[k] || accept[k]) begin
                    hold_d[k]    = in_data[k*DW +: DW];
                    pending_d[k] = 1'b1;
                end else begin
                    overrun[k] = 1'b1;
                end
            end else if (accept[k]) begin
                pending_d[k] = 1'b0;
            end
        end

        // A new overrun beats a same-cycle clear.
        overflow_d = (clr_overflow ? '0 : overflow_q) | overrun;

        if (flush) begin
            state_d      = S_COLLECT;
            idx_d        = '0;
            sink_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_COLLECT: begin
                    if (&pending_q) begin
                        state_d      = S_ISSUE;
                        sink_valid_d = 1'b1;
                        sink_data_d  = hold_q[0];
                        idx_d        = '0;
                    end
                end
                S_ISSUE: begin
                    if (xfer) begin
                        if (idx_q == LAST) begin
                            state_d      = S_COLLECT;
                            sink_valid_d = 1'b0;
                            idx_d        = '0;
                        end else begin
                            idx_d       = idx_next;
                            sink_data_d = hold_q[idx_next];
                        end
                    end
                end
                default: state_d = S_COLLECT;
            endcase
        end

        // Output demux. The FIR emits channels in the same fixed order, so a
        // free-running counter recovers the channel of each source beat.
        if (flush) begin
            ocnt_d = '0;
        end else if (fir_source_valid) begin
            out_data_d[ocnt_q]  = fir_source_data;
            out_valid_d[ocnt_q] = 1'b1;
            frame_valid_d       = (ocnt_q == LAST);
            ocnt_d              = (ocnt_q == LAST) ? '0 : ocnt_q + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_COLLECT;
            pending_q     <= '0;
            hold_q        <= '0;
            idx_q         <= '0;
            sink_valid_q  <= 1'b0;
            sink_data_q   <= '0;
            ocnt_q        <= '0;
            out_data_q    <= '0;
            out_valid_q   <= '0;
            frame_valid_q <= 1'b0;
            overflow_q    <= '0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            hold_q        <= hold_d;
            idx_q         <= idx_d;
            sink_valid_q  <= sink_valid_d;
            sink_data_q   <= sink_data_d;
            ocnt_q        <= ocnt_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            frame_valid_q <= frame_valid_d;
            overflow_q    <= overflow_d;
        end
    end

    assign fir_sink_data    = sink_data_q;
    assign fir_sink_valid   = sink_valid_q;
    assign fir_source_ready = 1'b1;
    assign out_data         = out_data_q;
    assign out_valid        = out_valid_q;
    assign frame_valid      = frame_valid_q;
    assign overflow         = overflow_q;
    assign busy             = (state_q == S_ISSUE);

endmodule

// File: tb/tb_fir_tdm_sequencer.sv
module tb_fir_tdm_sequencer;
    localparam int NCH = 2;
    localparam int DW  = 12;
    localparam int OW  = 12;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NCH-1:0]    in_valid = '0;
    logic [NCH*DW-1:0] in_data = '0;
    logic              flush = 1'b0;
    logic              clr_overflow = 1'b0;
    logic [DW-1:0]     fir_sink_data;
    logic              fir_sink_valid;
    logic              fir_sink_ready = 1'b1;
    logic [OW-1:0]     fir_source_data = '0;
    logic              fir_source_valid = 1'b0;
    logic              fir_source_ready;
    logic [NCH*OW-1:0] out_data;
    logic [NCH-1:0]    out_valid;
    logic              frame_valid;
    logic [NCH-1:0]    overflow;
    logic              busy;

    always #5 clk = ~clk;

    fir_tdm_sequencer #(.NCH(NCH), .DW(DW), .OW(OW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .flush(flush), .clr_overflow(clr_overflow),
        .fir_sink_data(fir_sink_data), .fir_sink_valid(fir_sink_valid),
        .fir_sink_ready(fir_sink_ready), .fir_source_data(fir_source_data),
        .fir_source_valid(fir_source_valid), .fir_source_ready(fir_source_ready),
        .out_data(out_data), .out_valid(out_valid), .frame_valid(frame_valid),
        .overflow(overflow), .busy(busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    task automatic drive(input logic [NCH-1:0] iv, input logic [NCH*DW-1:0] d,
                         input logic rdy, input logic fl, input logic clr,
                         input logic srcv, input logic [OW-1:0] srcd);
        in_valid         = iv;
        in_data          = d;
        fir_sink_ready   = rdy;
        flush            = fl;
        clr_overflow     = clr;
        fir_source_valid = srcv;
        fir_source_data  = srcd;
    endtask

    task automatic apply_reset();
        drive('0, '0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [NCH-1:0]    iv;
        logic [DW-1:0]     d0, d1;
        logic              rdy, fl, clr, srcv;
        logic [OW-1:0]     srcd;
        logic              e_sv;
        logic [DW-1:0]     e_sd;
        logic              e_busy;
        logic [NCH-1:0]    e_ovf, e_ov;
        logic              e_fv;
        logic [NCH*OW-1:0] e_od;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [1:0] iv, logic [11:0] d0, logic [11:0] d1,
                                logic rdy, logic fl, logic clr, logic srcv,
                                logic [11:0] srcd, logic e_sv, logic [11:0] e_sd,
                                logic e_busy, logic [1:0] e_ovf, logic [1:0] e_ov,
                                logic e_fv, logic [23:0] e_od);
        vec_t v;
        v.iv = iv; v.d0 = d0; v.d1 = d1; v.rdy = rdy; v.fl = fl; v.clr = clr;
        v.srcv = srcv; v.srcd = srcd; v.e_sv = e_sv; v.e_sd = e_sd;
        v.e_busy = e_busy; v.e_ovf = e_ovf; v.e_ov = e_ov; v.e_fv = e_fv;
        v.e_od = e_od;
        return v;
    endfunction

    // ---------------- behavioural reference model ----------------
    // Frames are snapshotted whole when the last slot fills; issue order is
    // then simply the position within the snapshot.
    logic [NCH-1:0]         m_pend;
    logic [NCH-1:0][DW-1:0] m_hold;
    logic [NCH-1:0][DW-1:0] m_frame;
    bit                     m_iss;
    int                     m_pos;
    logic [NCH-1:0]         m_ovf;
    logic [NCH-1:0][OW-1:0] m_out;
    logic [NCH-1:0]         m_ov;
    bit                     m_fv;
    int                     m_ocnt;

    task automatic model_reset();
        m_pend = '0; m_hold = '0; m_frame = '0; m_iss = 0; m_pos = 0;
        m_ovf = '0; m_out = '0; m_ov = '0; m_fv = 0; m_ocnt = 0;
    endtask

    task automatic model_step(input logic [NCH-1:0] iv, input logic [NCH*DW-1:0] d,
                              input logic rdy, input logic fl, input logic clr,
                              input logic srcv, input logic [OW-1:0] srcd);
        logic [NCH-1:0] old_pend;
        logic [NCH-1:0] ovr;
        bit take;
        int tk;
        old_pend = m_pend;
        ovr      = '0;
        take     = m_iss && rdy;
        tk       = m_pos;
        if (fl) begin
            m_pend = '0; m_iss = 0; m_pos = 0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (iv[k]) begin
                    if (!old_pend[k] || (take && tk == k)) begin
                        m_hold[k] = d[k*DW +: DW];
                        m_pend[k] = 1'b1;
                    end else begin
                        ovr[k] = 1'b1;
                    end
                end else if (take && tk == k) begin
                    m_pend[k] = 1'b0;
                end
            end
            if (take) begin
                if (m_pos == NCH - 1) begin m_iss = 0; m_pos = 0; end
                else m_pos++;
            end else if (!m_iss && (&old_pend)) begin
                m_iss = 1; m_pos = 0; m_frame = m_hold;
            end
        end
        m_ovf = (clr ? '0 : m_ovf) | ovr;
        m_ov  = '0;
        m_fv  = 0;
        if (fl) begin
            m_ocnt = 0;
        end else if (srcv) begin
            m_out[m_ocnt] = srcd;
            m_ov[m_ocnt]  = 1'b1;
            m_fv          = (m_ocnt == NCH - 1);
            m_ocnt        = (m_ocnt + 1) % NCH;
        end
    endtask

    initial begin
        // Table: inputs driven for one cycle, outputs checked just after that edge.
        //              iv    d0       d1       rdy fl clr sv srcd    | sv sd      busy ovf   ov    fv od
        vecs.push_back(mk(2'b11, 12'h123, 12'hE00, 1, 0, 0, 0, 12'h0, 0, 12'h0,   0, 2'b00, 2'b00, 0, 24'h0));
        vecs.push_back(mk(2'b00, 12'h0,   12'h0,   1, 0, 0, 0, 12'h0, 1, 12'h123, 1, 2'b00, 2'b00, 0, 24'h0));
        vecs.push_back(mk(2'b00, 12'h0,   12'h0,   1, 0, 0, 0, 12'h0, 1, 12'hE00, 1, 2'b00, 2'b00, 0, 24'h0));
        vecs.push_back(mk(2'b00, 12'h0,   12'h0,   1, 0, 0, 0, 12'h0, 0, 12'h0,   0, 2'b00, 2'b00, 0, 24'h0));
        vecs.push_back(mk(2'b00, 12'h0,   12'h0,   1, 0, 0, 0, 12'h0, 0, 12'h0,   0, 2'b00, 2'b00, 0, 24'h0));
        // back-pressure on ch0
        vecs.push_back(mk(2'b11, 12'h123, 12'hE00, 1, 0, 0, 0, 12'h0, 0, 12'h0,   0, 2'b00, 2'b00, 0, 24'h0));
        vecs.push_back(mk(2'b00, 12'h0,   12'h0,   1, 0, 0, 0, 12'h0, 1, 12'h123, 1, 2'b00, 2'b00, 0, 24'h0));
        vecs.push_back(mk(2'b00, 12'h0,   12'h0,   0, 0, 0, 0, 12'h0, 1, 12'h123, 1, 2'b00, 2'b00, 0, 24'h0));
        vecs.push_back(mk(2'b00, 12'h0,   12'h0,   0, 0, 0, 0, 12'h0, 1, 12'h123, 1, 2'b00, 2'b00, 0, 24'h0));
        vecs.push_back(mk(2'b00, 12'h0,   12'h0,   0, 0, 0, 0, 12'h0, 1, 12'h123, 1, 2'b00, 2'b00, 0, 24'h0));
        vecs.push_back(mk(2'b00, 12'h0,   12'h0,   1, 0, 0, 0, 12'h0, 1, 12'hE00, 1, 2'b00, 2'b00, 0, 24'h0));
        vecs.push_back(mk(2'b00, 12'h0,   12'h0,   1, 0, 0, 0, 12'h0, 0, 12'h0,   0, 2'b00, 2'b00, 0, 24'h0));
        // overrun on ch0, then clear
        vecs.push_back(mk(2'b01, 12'h010, 12'h0,   1, 0, 0, 0, 12'h0, 0, 12'h0,   0, 2'b00, 2'b00, 0, 24'h0));
        vecs.push_back(mk(2'b01, 12'h020, 12'h0,   1, 0, 0, 0, 12'h0, 0, 12'h0,   0, 2'b01, 2'b00, 0, 24'h0));
        vecs.push_back(mk(2'b10, 12'h0,   12'h0AA, 1, 0, 0, 0, 12'h0, 0, 12'h0,   0, 2'b01, 2'b00, 0, 24'h0));
        vecs.push_back(mk(2'b00, 12'h0,   12'h0,   1, 0, 0, 0, 12'h0, 1, 12'h010, 1, 2'b01, 2'b00, 0, 24'h0));
        vecs.push_back(mk(2'b00, 12'h0,   12'h0,   1, 0, 1, 0, 12'h0, 1, 12'h0AA, 1, 2'b00, 2'b00, 0, 24'h0));
        vecs.push_back(mk(2'b00, 12'h0,   12'h0,   1, 0, 0, 0, 12'h0, 0, 12'h0,   0, 2'b00, 2'b00, 0, 24'h0));
        // same-cycle re-latch of ch0
        vecs.push_back(mk(2'b11, 12'h033, 12'h044, 1, 0, 0, 0, 12'h0, 0, 12'h0,   0, 2'b00, 2'b00, 0, 24'h0));
        vecs.push_back(mk(2'b00, 12'h0,   12'h0,   1, 0, 0, 0, 12'h0, 1, 12'h033, 1, 2'b00, 2'b00, 0, 24'h0));
        vecs.push_back(mk(2'b01, 12'h055, 12'h0,   1, 0, 0, 0, 12'h0, 1, 12'h044, 1, 2'b00, 2'b00, 0, 24'h0));
        vecs.push_back(mk(2'b00, 12'h0,   12'h0,   1, 0, 0, 0, 12'h0, 0, 12'h0,   0, 2'b00, 2'b00, 0, 24'h0));
        vecs.push_back(mk(2'b10, 12'h0,   12'h066, 1, 0, 0, 0, 12'h0, 0, 12'h0,   0, 2'b00, 2'b00, 0, 24'h0));
        vecs.push_back(mk(2'b00, 12'h0,   12'h0,   1, 0, 0, 0, 12'h0, 1, 12'h055, 1, 2'b00, 2'b00, 0, 24'h0));
        vecs.push_back(mk(2'b00, 12'h0,   12'h0,   1, 0, 0, 0, 12'h0, 1, 12'h066, 1, 2'b00, 2'b00, 0, 24'h0));
        vecs.push_back(mk(2'b00, 12'h0,   12'h0,   1, 0, 0, 0, 12'h0, 0, 12'h0,   0, 2'b00, 2'b00, 0, 24'h0));
        // source demux
        vecs.push_back(mk(2'b00, 12'h0, 12'h0, 1, 0, 0, 1, 12'h7FF, 0, 12'h0, 0, 2'b00, 2'b01, 0, 24'h0007FF));
        vecs.push_back(mk(2'b00, 12'h0, 12'h0, 1, 0, 0, 1, 12'h800, 0, 12'h0, 0, 2'b00, 2'b10, 1, 24'h8007FF));
        vecs.push_back(mk(2'b00, 12'h0, 12'h0, 1, 0, 0, 0, 12'h0,   0, 12'h0, 0, 2'b00, 2'b00, 0, 24'h8007FF));
        // flush after ch0 only; flush beats a would-be overrun on ch0
        vecs.push_back(mk(2'b01, 12'h111, 12'h0,   1, 0, 0, 0, 12'h0, 0, 12'h0,   0, 2'b00, 2'b00, 0, 24'h8007FF));
        vecs.push_back(mk(2'b01, 12'h222, 12'h0,   1, 1, 0, 0, 12'h0, 0, 12'h0,   0, 2'b00, 2'b00, 0, 24'h8007FF));
        vecs.push_back(mk(2'b10, 12'h0,   12'h333, 1, 0, 0, 0, 12'h0, 0, 12'h0,   0, 2'b00, 2'b00, 0, 24'h8007FF));
        vecs.push_back(mk(2'b01, 12'h444, 12'h0,   1, 0, 0, 0, 12'h0, 0, 12'h0,   0, 2'b00, 2'b00, 0, 24'h8007FF));
        vecs.push_back(mk(2'b00, 12'h0,   12'h0,   1, 0, 0, 0, 12'h0, 1, 12'h444, 1, 2'b00, 2'b00, 0, 24'h8007FF));
        vecs.push_back(mk(2'b00, 12'h0,   12'h0,   1, 0, 0, 0, 12'h0, 1, 12'h333, 1, 2'b00, 2'b00, 0, 24'h8007FF));
        vecs.push_back(mk(2'b00, 12'h0,   12'h0,   1, 0, 0, 0, 12'h0, 0, 12'h0,   0, 2'b00, 2'b00, 0, 24'h8007FF));
        // flush restarts the output counter
        vecs.push_back(mk(2'b00, 12'h0, 12'h0, 1, 0, 0, 1, 12'h001, 0, 12'h0, 0, 2'b00, 2'b01, 0, 24'h800001));
        vecs.push_back(mk(2'b00, 12'h0, 12'h0, 1, 1, 0, 0, 12'h0,   0, 12'h0, 0, 2'b00, 2'b00, 0, 24'h800001));
        vecs.push_back(mk(2'b00, 12'h0, 12'h0, 1, 0, 0, 1, 12'h002, 0, 12'h0, 0, 2'b00, 2'b01, 0, 24'h800002));
        // flush in ISSUE while stalled
        vecs.push_back(mk(2'b11, 12'h5A5, 12'h6B6, 1, 0, 0, 0, 12'h0, 0, 12'h0,   0, 2'b00, 2'b00, 0, 24'h800002));
        vecs.push_back(mk(2'b00, 12'h0,   12'h0,   1, 0, 0, 0, 12'h0, 1, 12'h5A5, 1, 2'b00, 2'b00, 0, 24'h800002));
        vecs.push_back(mk(2'b00, 12'h0,   12'h0,   0, 1, 0, 0, 12'h0, 0, 12'h0,   0, 2'b00, 2'b00, 0, 24'h800002));
        vecs.push_back(mk(2'b00, 12'h0,   12'h0,   1, 0, 0, 0, 12'h0, 0, 12'h0,   0, 2'b00, 2'b00, 0, 24'h800002));

        // ---- reset state ----
        #1;
        chk("reset_sink_valid", fir_sink_valid, 1'b0);
        chk("reset_sink_data", fir_sink_data, '0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_overflow", overflow, '0);
        chk("reset_out_data", out_data, '0);
        chk("reset_out_valid", out_valid, '0);
        chk("reset_frame_valid", frame_valid, 1'b0);
        chk("source_ready", fir_source_ready, 1'b1);
        apply_reset();

        // ---- directed table ----
        foreach (vecs[i]) begin
            drive(vecs[i].iv, {vecs[i].d1, vecs[i].d0}, vecs[i].rdy, vecs[i].fl,
                  vecs[i].clr, vecs[i].srcv, vecs[i].srcd);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_sink_valid", i), fir_sink_valid, vecs[i].e_sv);
            if (vecs[i].e_sv)
                chk($sformatf("vec%0d_sink_data", i), fir_sink_data, vecs[i].e_sd);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
            chk($sformatf("vec%0d_overflow", i), overflow, vecs[i].e_ovf);
            chk($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].e_ov);
            chk($sformatf("vec%0d_frame_valid", i), frame_valid, vecs[i].e_fv);
            chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].e_od);
            @(negedge clk);
        end

        // ---- asynchronous reset mid-ISSUE ----
        drive(2'b11, {12'h654, 12'h321}, 1'b0, 1'b0, 1'b0, 1'b1, 12'h0AB);
        @(posedge clk); #1;
        @(negedge clk);
        drive('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        @(posedge clk); #1;
        chk("pre_rst_sink_valid", fir_sink_valid, 1'b1);
        chk("pre_rst_sink_data", fir_sink_data, 12'h321);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_sink_valid", fir_sink_valid, 1'b0);
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_out_data", out_data, '0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(2'b11, {12'h888, 12'h777}, 1'b1, 1'b0, 1'b0, 1'b1, 12'h0CD);
        @(posedge clk); #1;
        chk("post_rst_out_valid", out_valid, 2'b01);
        chk("post_rst_out_data", out_data, 24'h0000CD);
        @(negedge clk);
        drive('0, '0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        @(posedge clk); #1;
        chk("post_rst_first_ch0", fir_sink_data, 12'h777);
        @(negedge clk);
        @(posedge clk); #1;
        chk("post_rst_then_ch1", fir_sink_data, 12'h888);

        // ---- randomized run against the reference model ----
        @(negedge clk);
        apply_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [NCH-1:0]    iv;
            logic [NCH*DW-1:0] d;
            logic              rdy, fl, clr, srcv;
            logic [OW-1:0]     srcd;
            for (int k = 0; k < NCH; k++) iv[k] = ($urandom_range(0, 2) == 0);
            d    = NCH*DW'($urandom);
            rdy  = ($urandom_range(0, 3) != 0);
            fl   = ($urandom_range(0, 63) == 0);
            clr  = ($urandom_range(0, 31) == 0);
            srcv = ($urandom_range(0, 1) == 1);
            srcd = OW'($urandom);
            drive(iv, d, rdy, fl, clr, srcv, srcd);
            model_step(iv, d, rdy, fl, clr, srcv, srcd);
            @(posedge clk);
            #1;
            chk("rnd_sink_valid", fir_sink_valid, m_iss);
            if (m_iss) chk("rnd_sink_data", fir_sink_data, m_frame[m_pos]);
            chk("rnd_busy", busy, m_iss);
            chk("rnd_overflow", overflow, m_ovf);
            chk("rnd_out_valid", out_valid, m_ov);
            chk("rnd_frame_valid", frame_valid, m_fv);
            chk("rnd_out_data", out_data, m_out);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
